// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: symbol width, the four control tokens, and the
// receiver alignment state encoding.
package tmds_pkg;

  localparam int TMDS_SYM_W = 10;

  // Written symbol[9:0]; bit 0 is the first bit on the wire.
  localparam logic [TMDS_SYM_W-1:0] TOK_C00 = 10'b1101010100;
  localparam logic [TMDS_SYM_W-1:0] TOK_C01 = 10'b0010101011;
  localparam logic [TMDS_SYM_W-1:0] TOK_C10 = 10'b0101010100;
  localparam logic [TMDS_SYM_W-1:0] TOK_C11 = 10'b1010101011;

  typedef enum logic {
    ST_HUNT   = 1'b0,
    ST_LOCKED = 1'b1
  } tmds_state_e;

endpackage

// File: rtl/tmds_token_match.sv
// Combinational control-token detector; also used by the 10b->8b decoder.
module tmds_token_match
  import tmds_pkg::*;
(
  input  logic [TMDS_SYM_W-1:0] i_word,
  output logic                  o_is_ctrl,
  output logic [1:0]            o_ctrl
);

  always_comb begin
    o_is_ctrl = 1'b1;
    o_ctrl    = 2'b00;
    case (i_word)
      TOK_C00: o_ctrl = 2'b00;
      TOK_C01: o_ctrl = 2'b01;
      TOK_C10: o_ctrl = 2'b10;
      TOK_C11: o_ctrl = 2'b11;
      default: o_is_ctrl = 1'b0;
    endcase
  end

endmodule

// File: rtl/tmds_deserializer.sv
// One-channel TMDS deserializer: LSB-first serial in, 10-bit symbols out,
// with bit-slip symbol alignment driven by repeated control tokens.
module tmds_deserializer
  import tmds_pkg::*;
#(
  parameter int LOCK_COUNT = 8,
  parameter int HUNT_WORDS = 64,
  parameter int LOSS_WORDS = 4096
) (
  input  logic                  clk_TMDS,
  input  logic                  reset,
  input  logic                  TMDS_serial,
  output logic [TMDS_SYM_W-1:0] TMDS_word,
  output logic                  word_valid,
  output logic                  is_ctrl,
  output logic [1:0]            ctrl,
  output logic                  locked,
  output logic [3:0]            slip_count
);

  localparam int MW = $clog2(LOCK_COUNT + 1);
  localparam int HW = $clog2(HUNT_WORDS + 1);
  localparam int LW = $clog2(LOSS_WORDS + 1);
  localparam logic [MW-1:0] MATCH_LAST = MW'(LOCK_COUNT - 1);
  localparam logic [HW-1:0] MISS_LAST  = HW'(HUNT_WORDS - 1);
  localparam logic [LW-1:0] LOSS_LAST  = LW'(LOSS_WORDS - 1);

  // Only the 9 most recent bits are kept; the 10th is the live input.
  logic [TMDS_SYM_W-2:0] r_sr;
  logic [3:0]            r_bit_cnt;
  logic                  r_slip_pend;
  tmds_state_e           r_state;
  logic [MW-1:0]         r_match;
  logic [HW-1:0]         r_miss;
  logic [LW-1:0]         r_loss;

  logic [TMDS_SYM_W-1:0] w_word;
  logic                  w_cap;
  logic                  w_slip_now;
  logic                  w_is_ctrl;
  logic [1:0]            w_ctrl;

  assign w_word     = {TMDS_serial, r_sr};
  assign w_cap      = (r_bit_cnt == 4'd9);
  assign w_slip_now = (r_bit_cnt == 4'd0) && r_slip_pend;

  tmds_token_match u_match (
    .i_word    (w_word),
    .o_is_ctrl (w_is_ctrl),
    .o_ctrl    (w_ctrl)
  );

  always_ff @(posedge clk_TMDS or posedge reset) begin
    if (reset) begin
      r_sr        <= '0;
      r_bit_cnt   <= '0;
      r_slip_pend <= 1'b0;
      r_state     <= ST_HUNT;
      r_match     <= '0;
      r_miss      <= '0;
      r_loss      <= '0;
      TMDS_word   <= '0;
      word_valid  <= 1'b0;
      is_ctrl     <= 1'b0;
      ctrl        <= 2'b00;
      locked      <= 1'b0;
      slip_count  <= '0;
    end else begin
      word_valid <= 1'b0;
      r_sr       <= w_word[TMDS_SYM_W-1:1];

      // A slip holds bit_cnt at 0 one extra cycle, stretching the word to 11 bits.
      if (w_slip_now) begin
        r_slip_pend <= 1'b0;
        slip_count  <= (slip_count == 4'd9) ? 4'd0 : slip_count + 4'd1;
      end else if (w_cap) begin
        r_bit_cnt <= '0;
      end else begin
        r_bit_cnt <= r_bit_cnt + 4'd1;
      end

      if (w_cap) begin
        TMDS_word  <= w_word;
        word_valid <= 1'b1;
        is_ctrl    <= w_is_ctrl;
        ctrl       <= w_ctrl;
        case (r_state)
          ST_HUNT: begin
            if (w_is_ctrl) begin
              r_miss <= '0;
              if (r_match >= MATCH_LAST) begin
                r_state <= ST_LOCKED;
                locked  <= 1'b1;
                r_match <= '0;
                r_loss  <= '0;
              end else begin
                r_match <= r_match + 1'b1;
              end
            end else begin
              r_match <= '0;
              if (r_miss >= MISS_LAST) begin
                r_miss      <= '0;
                r_slip_pend <= 1'b1;
              end else begin
                r_miss <= r_miss + 1'b1;
              end
            end
          end
          ST_LOCKED: begin
            if (w_is_ctrl) begin
              r_loss <= '0;
            end else if (r_loss >= LOSS_LAST) begin
              r_state <= ST_HUNT;
              locked  <= 1'b0;
              r_match <= '0;
              r_miss  <= '0;
              r_loss  <= '0;
            end else begin
              r_loss <= r_loss + 1'b1;
            end
          end
          default: r_state <= ST_HUNT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tmds_deserializer.sv
// Self-checking bench for tmds_deserializer against a bit-queue reference model.
module tb_tmds_deserializer;

  localparam int LOCK_COUNT = 8;
  localparam int HUNT_WORDS = 4;
  localparam int LOSS_WORDS = 16;

  logic       clk_TMDS = 1'b0;
  logic       reset = 1'b0;
  logic       TMDS_serial = 1'b0;
  logic [9:0] TMDS_word;
  logic       word_valid;
  logic       is_ctrl;
  logic [1:0] ctrl;
  logic       locked;
  logic [3:0] slip_count;

  int nvec = 0;
  int nerr = 0;

  always #5 clk_TMDS = ~clk_TMDS;

  tmds_deserializer #(
    .LOCK_COUNT (LOCK_COUNT),
    .HUNT_WORDS (HUNT_WORDS),
    .LOSS_WORDS (LOSS_WORDS)
  ) dut (
    .clk_TMDS    (clk_TMDS),
    .reset       (reset),
    .TMDS_serial (TMDS_serial),
    .TMDS_word   (TMDS_word),
    .word_valid  (word_valid),
    .is_ctrl     (is_ctrl),
    .ctrl        (ctrl),
    .locked      (locked),
    .slip_count  (slip_count)
  );

  bit [9:0] TOK [4] = '{10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011};

  // Reference model: words are the last 10 bits of a 10-bit (or 11-bit after slip) interval.
  bit       q[$];
  int       m_cnt, m_need, m_match, m_miss, m_loss, m_slips;
  bit       m_locked, m_pend, m_vld, m_isc;
  bit [9:0] m_word;
  bit [1:0] m_ctrl;

  task automatic m_reset();
    q.delete();
    m_cnt = 0; m_need = 10; m_match = 0; m_miss = 0; m_loss = 0; m_slips = 0;
    m_locked = 0; m_pend = 0; m_vld = 0; m_isc = 0; m_word = '0; m_ctrl = '0;
  endtask

  task automatic m_step(input bit b);
    bit [9:0] w;
    bit       tok;
    bit [1:0] idx;
    m_vld = 0;
    q.push_back(b);
    if (q.size() > 10) void'(q.pop_front());
    m_cnt++;
    if (m_cnt == 1 && m_pend) begin
      m_pend  = 0;
      m_need  = 11;
      m_slips = (m_slips + 1) % 10;
    end
    if (m_cnt == m_need) begin
      m_cnt = 0; m_need = 10;
      for (int i = 0; i < 10; i++) w[i] = q[i];
      tok = 0; idx = 0;
      for (int k = 0; k < 4; k++) if (w == TOK[k]) begin tok = 1; idx = 2'(k); end
      m_vld = 1; m_word = w; m_isc = tok; m_ctrl = tok ? idx : 2'b00;
      if (!m_locked) begin
        if (tok) begin
          m_miss = 0; m_match++;
          if (m_match >= LOCK_COUNT) begin m_locked = 1; m_loss = 0; end
        end else begin
          m_match = 0; m_miss++;
          if (m_miss >= HUNT_WORDS) begin m_pend = 1; m_miss = 0; end
        end
      end else begin
        if (tok) m_loss = 0;
        else begin
          m_loss++;
          if (m_loss >= LOSS_WORDS) begin m_locked = 0; m_match = 0; m_miss = 0; m_loss = 0; end
        end
      end
    end
  endtask

  function automatic logic [18:0] m_exp();
    return {m_vld, m_word, m_isc, m_ctrl, m_locked, 4'(m_slips)};
  endfunction

  function automatic logic [18:0] dut_vec();
    return {word_valid, TMDS_word, is_ctrl, ctrl, locked, slip_count};
  endfunction

  task automatic send_bit(input bit b);
    TMDS_serial = b;
    @(posedge clk_TMDS);
    #1;
    m_step(b);
  endtask

  task automatic do_reset();
    TMDS_serial = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk_TMDS);
    #1 reset = 1'b0;
    m_reset();
  endtask

  task automatic test_reset();
    #1 reset = 1'b1;
    #1;
    if (dut_vec() !== 19'd0) begin nerr++; $display("FAIL reset_async: got %h want 0", dut_vec()); end
    nvec++;
    repeat (2) @(posedge clk_TMDS);
    #1 reset = 1'b0;
    m_reset();
    if (dut_vec() !== 19'd0) begin nerr++; $display("FAIL reset_release: got %h want 0", dut_vec()); end
    nvec++;
  endtask

  task automatic test_zero_word();
    for (int i = 0; i < 10; i++) begin
      send_bit(1'b0);
      if (word_valid !== (i == 9)) begin nerr++; $display("FAIL zero_valid bit %0d: got %b", i, word_valid); end
      nvec++;
      if (dut_vec() !== m_exp()) begin nerr++; $display("FAIL zero_model bit %0d: got %h want %h", i, dut_vec(), m_exp()); end
      nvec++;
    end
    if (TMDS_word !== 10'd0 || locked !== 1'b0) begin
      nerr++; $display("FAIL zero_word: got word %h locked %b want 0/0", TMDS_word, locked);
    end
    nvec++;
  endtask

  task automatic test_aligned_lock();
    for (int w = 0; w < 10; w++) begin
      for (int i = 0; i < 10; i++) begin
        send_bit(TOK[0][i]);
        if (dut_vec() !== m_exp()) begin nerr++; $display("FAIL aligned w%0d b%0d: got %h want %h", w, i, dut_vec(), m_exp()); end
        nvec++;
      end
      if (word_valid !== 1'b1 || is_ctrl !== 1'b1 || ctrl !== 2'b00 || locked !== (w >= 7)) begin
        nerr++; $display("FAIL aligned_word %0d: got v%b c%b ctrl%b l%b", w, word_valid, is_ctrl, ctrl, locked);
      end
      nvec++;
    end
    if (slip_count !== 4'd0) begin nerr++; $display("FAIL aligned_slips: got %0d want 0", slip_count); end
    nvec++;
  endtask

  task automatic test_slip_lock();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      send_bit(1'b0);
      if (dut_vec() !== m_exp()) begin nerr++; $display("FAIL slip_pre b%0d: got %h want %h", i, dut_vec(), m_exp()); end
      nvec++;
    end
    for (int w = 0; w < 40; w++)
      for (int i = 0; i < 10; i++) begin
        send_bit(TOK[0][i]);
        if (dut_vec() !== m_exp()) begin nerr++; $display("FAIL slip w%0d b%0d: got %h want %h", w, i, dut_vec(), m_exp()); end
        nvec++;
      end
    if (slip_count !== 4'd3 || locked !== 1'b1) begin
      nerr++; $display("FAIL slip_final: got slips %0d locked %b want 3/1", slip_count, locked);
    end
    nvec++;
  endtask

  task automatic test_loss();
    bit [9:0] w;
    for (int n = 0; n < 32; n++) begin
      w = (n == 15) ? TOK[0] : 10'h1F0;
      for (int i = 0; i < 10; i++) begin
        send_bit(w[i]);
        if (dut_vec() !== m_exp()) begin nerr++; $display("FAIL loss w%0d b%0d: got %h want %h", n, i, dut_vec(), m_exp()); end
        nvec++;
      end
      if (locked !== (n < 31)) begin nerr++; $display("FAIL loss_locked w%0d: got %b want %b", n, locked, (n < 31)); end
      nvec++;
    end
  endtask

  task automatic test_token_data();
    bit [9:0] w;
    for (int n = 0; n < 10; n++) begin
      w = (n < 8) ? TOK[0] : (n == 8) ? TOK[3] : 10'h2AA;
      for (int i = 0; i < 10; i++) begin
        send_bit(w[i]);
        if (dut_vec() !== m_exp()) begin nerr++; $display("FAIL tokdata w%0d b%0d: got %h want %h", n, i, dut_vec(), m_exp()); end
        nvec++;
      end
    end
    if (is_ctrl !== 1'b0 || ctrl !== 2'b00 || TMDS_word !== 10'h2AA || locked !== 1'b1) begin
      nerr++; $display("FAIL tokdata_data: got c%b ctrl%b word %h l%b", is_ctrl, ctrl, TMDS_word, locked);
    end
    nvec++;
  endtask

  task automatic test_ctrl11();
    for (int i = 0; i < 10; i++) begin
      send_bit(TOK[3][i]);
      if (dut_vec() !== m_exp()) begin nerr++; $display("FAIL ctrl11 b%0d: got %h want %h", i, dut_vec(), m_exp()); end
      nvec++;
    end
    if (is_ctrl !== 1'b1 || ctrl !== 2'b11 || TMDS_word !== TOK[3]) begin
      nerr++; $display("FAIL ctrl11_word: got c%b ctrl%b word %h want 1/11/%h", is_ctrl, ctrl, TMDS_word, TOK[3]);
    end
    nvec++;
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 5; i++) send_bit(TOK[0][i]);
    #2 reset = 1'b1;
    #1;
    if (dut_vec() !== 19'd0) begin nerr++; $display("FAIL midreset_clear: got %h want 0", dut_vec()); end
    nvec++;
    repeat (2) @(posedge clk_TMDS);
    #1 reset = 1'b0;
    m_reset();
    for (int w = 0; w < 10; w++)
      for (int i = 0; i < 10; i++) begin
        send_bit(TOK[0][i]);
        if (dut_vec() !== m_exp()) begin nerr++; $display("FAIL midreset w%0d b%0d: got %h want %h", w, i, dut_vec(), m_exp()); end
        nvec++;
      end
    if (locked !== 1'b1 || slip_count !== 4'd0) begin
      nerr++; $display("FAIL midreset_relock: got l%b slips %0d want 1/0", locked, slip_count);
    end
    nvec++;
  endtask

  task automatic test_random();
    bit [9:0] w;
    int       kind, len;
    for (int blk = 0; blk < 80; blk++) begin
      kind = $urandom_range(0, 2);
      if (kind == 0) begin
        len = $urandom_range(1, 9);
        for (int i = 0; i < len; i++) begin
          send_bit(1'($urandom_range(0, 1)));
          if (dut_vec() !== m_exp()) begin nerr++; $display("FAIL rand_junk blk%0d: got %h want %h", blk, dut_vec(), m_exp()); end
          nvec++;
        end
      end else begin
        len = (kind == 1) ? 12 : $urandom_range(1, 20);
        for (int n = 0; n < len; n++) begin
          w = (kind == 1) ? TOK[$urandom_range(0, 3)] : 10'($urandom_range(0, 1023));
          for (int i = 0; i < 10; i++) begin
            send_bit(w[i]);
            if (dut_vec() !== m_exp()) begin nerr++; $display("FAIL rand blk%0d w%0d b%0d: got %h want %h", blk, n, i, dut_vec(), m_exp()); end
            nvec++;
          end
        end
      end
    end
  endtask

  initial begin
    m_reset();
    test_reset();
    test_zero_word();
    test_aligned_lock();
    test_slip_lock();
    test_loss();
    test_token_data();
    test_ctrl11();
    test_mid_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
